// File: rtl/signal_gen_tx.sv
// signal_gen_tx: programmable square-wave transmitter with a valid/ready config port.
// Define SIGGEN_BURST_EN to enable burst mode (cfg_count, DONE state, done pulse).
module signal_gen_tx #(
   parameter int          CNT_W      = 32,
   parameter int unsigned DEF_PERIOD = 32'd50_000_000,
   parameter int unsigned DEF_HIGH   = 32'd25_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CNT_W-1:0] cfg_period,
   input  logic [CNT_W-1:0] cfg_high,
   input  logic [CNT_W-1:0] cfg_count,
   output logic             signal_out,
   output logic             period_start,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
`ifdef SIGGEN_BURST_EN
      S_DONE = 2'd2,
`endif
      S_RUN  = 2'd1
   } state_t;

   function automatic logic [CNT_W-1:0] clamp_p(input logic [CNT_W-1:0] p);
      logic [CNT_W-1:0] v;
      if (p < CNT_W'(2)) v = CNT_W'(2);
      else               v = p;
      return v;
   endfunction

   // High time is forced into 1..P-1 so each period has exactly one rise and one fall.
   function automatic logic [CNT_W-1:0] clamp_h(input logic [CNT_W-1:0] p,
                                                 input logic [CNT_W-1:0] h);
      logic [CNT_W-1:0] pc;
      logic [CNT_W-1:0] v;
      pc = clamp_p(p);
      if (h == {CNT_W{1'b0}}) v = CNT_W'(1);
      else                    v = h;
      if (v >= pc) v = pc - CNT_W'(1);
      return v;
   endfunction

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_p, r_h, r_pend_p, r_pend_h, r_cnt;
   logic [CNT_W-1:0] w_p_nxt, w_h_nxt, w_cnt_nxt;
   logic             r_pend_full, r_sig, r_ps, r_busy, r_done;
   logic             w_apply, w_boundary, w_done_nxt;
`ifdef SIGGEN_BURST_EN
   logic [CNT_W-1:0] r_n, r_pend_n, r_pcnt, w_n_nxt, w_pcnt_nxt;
`else
   logic             w_unused_cnt;
   assign w_unused_cnt = ^cfg_count;
`endif

   assign cfg_ready    = ~r_pend_full;
   assign signal_out   = r_sig;
   assign period_start = r_ps;
   assign busy         = r_busy;
   assign done         = r_done;
   assign w_boundary   = (r_cnt == (r_p - CNT_W'(1)));

   // Next-state, phase counter and active-set update
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_apply     = 1'b0;
      w_done_nxt  = 1'b0;
`ifdef SIGGEN_BURST_EN
      w_pcnt_nxt  = r_pcnt;
`endif
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = {CNT_W{1'b0}};
            w_apply   = r_pend_full;
            if (enable) begin
               w_state_nxt = S_RUN;
`ifdef SIGGEN_BURST_EN
               w_pcnt_nxt  = {CNT_W{1'b0}};
`endif
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_RUN: begin
            if (w_boundary) begin
               w_cnt_nxt = {CNT_W{1'b0}};
               w_apply   = r_pend_full;
`ifdef SIGGEN_BURST_EN
               if (r_pcnt == {CNT_W{1'b1}}) w_pcnt_nxt = r_pcnt;
               else                         w_pcnt_nxt = r_pcnt + CNT_W'(1);
`endif
               if (!enable) begin
                  w_state_nxt = S_IDLE;
`ifdef SIGGEN_BURST_EN
               end else if ((r_n != {CNT_W{1'b0}}) &&
                            (({1'b0, r_pcnt} + {{CNT_W{1'b0}}, 1'b1}) >= {1'b0, r_n})) begin
                  w_state_nxt = S_DONE;
                  w_pcnt_nxt  = r_n;
`endif
               end else begin
                  w_state_nxt = S_RUN;
               end
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
`ifdef SIGGEN_BURST_EN
         S_DONE: begin
            w_cnt_nxt = {CNT_W{1'b0}};
            if (!enable) w_state_nxt = S_IDLE;
            else         w_state_nxt = S_DONE;
         end
`endif
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = {CNT_W{1'b0}};
         end
      endcase
      if (w_apply) begin
         w_p_nxt = clamp_p(r_pend_p);
         w_h_nxt = clamp_h(r_pend_p, r_pend_h);
      end else begin
         w_p_nxt = r_p;
         w_h_nxt = r_h;
      end
`ifdef SIGGEN_BURST_EN
      if (w_apply) w_n_nxt = r_pend_n;
      else         w_n_nxt = r_n;
      w_done_nxt = (w_state_nxt == S_DONE) && (r_state != S_DONE);
`endif
   end

   // State, settings and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_p         <= clamp_p(CNT_W'(DEF_PERIOD));
         r_h         <= clamp_h(CNT_W'(DEF_PERIOD), CNT_W'(DEF_HIGH));
         r_pend_p    <= {CNT_W{1'b0}};
         r_pend_h    <= {CNT_W{1'b0}};
         r_pend_full <= 1'b0;
         r_cnt       <= {CNT_W{1'b0}};
         r_sig       <= 1'b0;
         r_ps        <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
`ifdef SIGGEN_BURST_EN
         r_n         <= {CNT_W{1'b0}};
         r_pend_n    <= {CNT_W{1'b0}};
         r_pcnt      <= {CNT_W{1'b0}};
`endif
      end else begin
         r_state <= w_state_nxt;
         r_p     <= w_p_nxt;
         r_h     <= w_h_nxt;
         r_cnt   <= w_cnt_nxt;
         r_sig   <= (w_state_nxt == S_RUN) && (w_cnt_nxt < w_h_nxt);
         r_ps    <= (w_state_nxt == S_RUN) && (w_cnt_nxt == {CNT_W{1'b0}});
         r_busy  <= (w_state_nxt == S_RUN);
         r_done  <= w_done_nxt;
`ifdef SIGGEN_BURST_EN
         r_n     <= w_n_nxt;
         r_pcnt  <= w_pcnt_nxt;
`endif
         // Apply needs pend_full, accept needs it clear, so the two never collide.
         if (w_apply) begin
            r_pend_full <= 1'b0;
         end else if (cfg_valid && !r_pend_full) begin
            r_pend_full <= 1'b1;
            r_pend_p    <= cfg_period;
            r_pend_h    <= cfg_high;
`ifdef SIGGEN_BURST_EN
            r_pend_n    <= cfg_count;
`endif
         end
      end
   end

endmodule
